aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
- Sequential AES key-schedule engine for a key length set by parameter: AES-128, AES-192 or AES-256.
- Generates one 32-bit schedule word per clock.
- Emits each 128-bit round key through a valid/ready stream to the round datapath or to a round-key store.
- Generalises the fixed 128-bit expansion used by the current encrypt pipeline, and adds backpressure, a start/done handshake and round-key indexing.

Parameters:
- NK, default 4: key length in 32-bit words. Legal values are 4, 6 and 8; any other value is an elaboration error.
- NR, derived as NK+6 (localparam): round count. Total schedule words are 4*(NR+1): 44, 52 or 60.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset. 0 clears all state immediately.
- start, input, 1: request expansion. Sampled only when busy=0.
- key_in, input, 256: cipher key, MSB-aligned. Bits [255 -: NK*32] are used, with w0 at bits [255:224]. Unused LSBs are ignored.
- rk_ready, input, 1: consumer accepts rk_out on an edge where rk_valid=1 and rk_ready=1.
- rk_out, output, 128: round key r, formed as w[4r] in [127:96] through w[4r+3] in [31:0].
- rk_index, output, 4: round number r of rk_out, range 0..NR.
- rk_valid, output, 1: rk_out holds an unaccepted round key.
- busy, output, 1: expansion in progress.
- done, output, 1: one-cycle pulse after round key NR is accepted.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; rk_out=0, rk_index=0, rk_valid=0, busy=0, done=0; word counter i=0; Rcon=0x01.
- States:
  - IDLE: start=1 at an edge loads the NK key words into the sliding window, sets i=0, Rcon=0x01 and busy=1, then moves to GEN.
  - GEN: produces word i on each edge unless stalled.
  - DONE: after the edge that accepts round key NR, done=1 and busy=0 for exactly one cycle, then IDLE.
- key_in is captured only at start acceptance; later changes have no effect. start while busy=1 is ignored.
- Word rule:
  - i<NK: w[i]=key word i.
  - i>=NK and i mod NK==0: w[i] = w[i-NK] ^ SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}. Then Rcon <= xtime(Rcon), where xtime(x) = x<<1, reduced by ^0x1B when bit 7 is set.
  - NK==8 and i mod 8==4: w[i] = w[i-NK] ^ SubWord(w[i-1]).
  - Otherwise: w[i] = w[i-NK] ^ w[i-1].
- Window: an NK-word shift register holds w[i-NK..i-1]. SubWord uses 4 instances of the team's combinational aes_sbox (8-bit in, 8-bit out).
- Assembly: words with i mod 4 = 0..2 go into a 96-bit assembly buffer. The edge producing word i mod 4 = 3 writes {buffer, w[i]} to rk_out, sets rk_valid=1 and sets rk_index=i/4.
- Stall: if word i has i mod 4==3 and rk_valid=1 with rk_ready=0, no word is produced that edge; i, window and Rcon hold. If rk_valid=1 and rk_ready=1 on that edge, accept and reload happen on the same edge with no bubble.
- Acceptance without reload: rk_valid clears. rk_out and rk_index hold their last value.
- Latency: start accepted at edge E0 gives word i at edge E(i+1). Round key 0 is valid after E4. With rk_ready held at 1, a new round key arrives every 4 cycles and round key NR is valid after E(4*NR+4). done follows the edge that accepts round key NR.
- rk_ready while rk_valid=0 has no effect.
- Reset mid-expansion aborts immediately. No done pulse is issued and the next start begins from scratch.

Test Plan:
- NK=4, key 000102030405060708090a0b0c0d0e0f, rk_ready=1:
  - round 0 = 000102030405060708090a0b0c0d0e0f;
  - round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe;
  - round 10 = 13111d7fe3944a17f307a78b4d2b30c5;
  - rk_valid first high after E4, then every 4 cycles; done one cycle after round 10 is accepted; 11 keys total.
- NK=6, key 000102...1617: round 12 = a4970a331a78dc09c418c271e3a41d5d; 13 keys; rk_index ends at 12.
- NK=8, key 000102...1e1f: round 14 = 24fc79ccbf0979e9371ac23c6d68de36; 15 keys.
  - Confirms the i mod 8==4 SubWord path.
- Backpressure, NK=4: rk_ready driven by a random 30% pattern.
  - Same 11 keys appear in order, none lost or duplicated.
  - rk_out and rk_index stable while rk_valid=1 and rk_ready=0.
  - Total cycles = 44 + stall cycles.
- start pulsed with a different key_in while busy=1: ignored, output sequence unchanged. key_in changed after acceptance: no effect.
- reset=0 asserted asynchronously mid-clock while rk_index=5:
  - all outputs 0 immediately;
  - no done pulse;
  - a new start reproduces the full sequence from round 0.

Source files
------------

// File: rtl/aes_key_expand.sv
// aes_key_expand: sequential AES-128/192/256 key schedule, one word per clock,
// emitting each 128-bit round key over a valid/ready stream.
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_s = SBOX[i_a];
endmodule

module aes_key_expand #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] key_in,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_index,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_GEN = 2'd1, S_DONE = 2'd2;

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_key_expand: NK must be 4, 6 or 8");
  end
  if (NK < 8) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^key_in[255-32*NK:0];
  end

  logic [1:0]         r_state;
  logic [NK-1:0][31:0] r_win;
  logic [5:0]         r_i;
  logic [2:0]         r_k;
  logic [7:0]         r_rcon;
  logic [95:0]        r_buf;
  logic [127:0]       r_rk_out;
  logic [3:0]         r_rk_index;
  logic               r_rk_valid;

  logic [NK-1:0][31:0] w_load;
  logic [31:0] w_prev, w_old, w_sub_in, w_sub, w_new;
  logic        w_first, w_key, w_stall, w_step, w_acc;

  genvar b;
  for (b = 0; b < NK; b++) begin : g_load
    assign w_load[b] = key_in[255-32*b -: 32];
  end
  for (b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.i_a(w_sub_in[8*b +: 8]), .o_s(w_sub[8*b +: 8]));
  end

  // window: r_win[0] = w[i-NK], r_win[NK-1] = w[i-1]; key words recirculate for i < NK
  assign w_prev   = r_win[NK-1];
  assign w_old    = r_win[0];
  assign w_first  = r_i < 6'(NK);
  assign w_sub_in = (NK == 8 && r_k == 3'd4) ? w_prev : {w_prev[23:0], w_prev[31:24]};
  assign w_key    = r_i[1:0] == 2'd3;
  assign w_acc    = r_rk_valid & rk_ready;
  assign w_stall  = w_key & r_rk_valid & ~rk_ready;
  assign w_step   = r_state == S_GEN && r_i != 6'(NW) && !w_stall;

  always_comb
    w_new = w_first ? w_old :
            r_k == 3'd0 ? w_old ^ w_sub ^ {r_rcon, 24'h0} :
            (NK == 8 && r_k == 3'd4) ? w_old ^ w_sub : w_old ^ w_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_win      <= '0;
      r_i        <= '0;
      r_k        <= '0;
      r_rcon     <= 8'h01;
      r_buf      <= '0;
      r_rk_out   <= '0;
      r_rk_index <= '0;
      r_rk_valid <= 1'b0;
    end else begin
      r_rk_valid <= (w_step && w_key) || (r_rk_valid && !rk_ready);
      if (r_state == S_IDLE && start) begin
        r_state <= S_GEN;
        r_win   <= w_load;
        r_i     <= '0;
        r_k     <= '0;
        r_rcon  <= 8'h01;
      end
      if (r_state == S_DONE) r_state <= S_IDLE;
      if (r_state == S_GEN && r_i == 6'(NW) && w_acc) r_state <= S_DONE;
      if (w_step) begin
        r_win <= {w_new, r_win[NK-1:1]};
        r_i   <= r_i + 6'd1;
        r_k   <= (r_k == 3'(NK-1)) ? 3'd0 : r_k + 3'd1;
        if (!w_first && r_k == 3'd0) r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
        if (w_key) begin
          r_rk_out   <= {r_buf, w_new};
          r_rk_index <= r_i[5:2];
        end else r_buf <= {r_buf[63:0], w_new};
      end
    end
  end

  assign rk_out   = r_rk_out;
  assign rk_index = r_rk_index;
  assign rk_valid = r_rk_valid;
  assign busy     = r_state == S_GEN;
  assign done     = r_state == S_DONE;
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed checks of the key schedule for NK=4/6/8 against
// FIPS-197 vectors and a behavioural expansion model.
module tb_aes_key_expand;
  logic         clk, reset;
  logic         start [3];
  logic [255:0] key   [3];
  logic         rdy   [3];
  logic [127:0] rko   [3];
  logic [3:0]   rki   [3];
  logic         vld   [3], bsy [3], dn [3];

  int errs = 0, checks = 0;
  logic [7:0]   sbt [256];
  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [15];

  localparam logic [255:0] K4 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K6 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_key_expand #(.NK(4 + 2*g)) u_dut (
      .clk(clk), .reset(reset), .start(start[g]), .key_in(key[g]), .rk_ready(rdy[g]),
      .rk_out(rko[g]), .rk_index(rki[g]), .rk_valid(vld[g]), .busy(bsy[g]), .done(dn[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int j = 0; j < 8; j++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; r = inv;
      for (int j = 0; j < 4; j++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      sbt[x] = s ^ 8'h63;
    end
  endtask

  task automatic model(input int nk, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) w[i] = k[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk == 8 && i % 8 == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nk + 6; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // mode 0: ready high; 1: random 30% stall; 2: start/key_in disturbed while busy; 3: abort at index 5
  task automatic expand(input int g, input logic [255:0] k, input int mode);
    int nr, c, got;
    logic prev_hold, last_acc, fin;
    logic [127:0] h_o;
    logic [3:0]   h_i;
    nr = 4 + 2*g + 6;
    model(4 + 2*g, k);
    @(negedge clk);
    key[g] = k; start[g] = 1'b1; rdy[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    if (mode == 2) key[g] = ~k;
    c = 1; got = 0; prev_hold = 0; last_acc = 0; fin = 0;
    while (!fin && c < 1000) begin
      if (prev_hold && vld[g]) begin
        chk($sformatf("hold_out_nk%0d", 4+2*g), rko[g], h_o);
        chk($sformatf("hold_idx_nk%0d", 4+2*g), 128'(rki[g]), 128'(h_i));
      end
      if (dn[g]) begin
        chk("done_follows_last_accept", 128'(last_acc), 128'd1);
        chk("busy_low_at_done", 128'(bsy[g]), 128'd0);
        fin = 1;
      end else begin
        if (mode == 3 && vld[g] && rki[g] == 4'd5) begin
          #2 reset = 1'b0;
          #1;
          chk("abort_rk_out", rko[g], 128'd0);
          chk("abort_rk_index", 128'(rki[g]), 128'd0);
          chk("abort_flags", {125'd0, vld[g], bsy[g], dn[g]}, 128'd0);
          for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("abort_no_done", 128'(dn[g]), 128'd0);
          end
          reset = 1'b1;
          return;
        end
        if (mode == 2 && c == 10) begin
          start[g] = 1'b1;
          key[g] = {K8[127:0], K8[255:128]};
        end else start[g] = 1'b0;
        rdy[g] = (mode == 1) ? ($urandom_range(0, 99) >= 30) : 1'b1;
        last_acc = 0;
        if (vld[g] && rdy[g]) begin
          if (got < 15) begin
            got_rk[got] = rko[g];
            chk($sformatf("nk%0d_round%0d", 4+2*g, got), rko[g], exp_rk[got]);
          end
          chk($sformatf("nk%0d_index%0d", 4+2*g, got), 128'(rki[g]), 128'(got));
          if (mode == 0 && g == 0) chk($sformatf("accept_cycle%0d", got), 128'(c), 128'(5 + 4*got));
          last_acc = (got == nr);
          got++;
        end
        prev_hold = vld[g] && !rdy[g];
        h_o = rko[g]; h_i = rki[g];
        @(negedge clk);
        c++;
      end
    end
    chk("finished_in_budget", 128'(fin), 128'd1);
    chk($sformatf("key_count_nk%0d", 4+2*g), 128'(got), 128'(nr + 1));
    @(negedge clk);
    chk("done_one_cycle", {126'd0, dn[g], bsy[g]}, 128'd0);
  endtask

  initial begin
    build_sbox();
    reset = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0; key[g] = '0; rdy[g] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset_out%0d", g), rko[g], 128'd0);
      chk($sformatf("reset_idx%0d", g), 128'(rki[g]), 128'd0);
      chk($sformatf("reset_flags%0d", g), {125'd0, vld[g], bsy[g], dn[g]}, 128'd0);
    end
    reset = 1'b1;

    expand(0, K4, 0);
    chk("fips_r0", got_rk[0], 128'h000102030405060708090a0b0c0d0e0f);
    chk("fips_r1", got_rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("fips_r10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    expand(1, K6, 0);
    chk("fips192_r12", got_rk[12], 128'ha4970a331a78dc09c418c271e3a41d5d);
    chk("nk6_last_index", 128'(rki[1]), 128'd12);

    expand(2, K8, 0);
    chk("fips256_r14", got_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    expand(0, K4, 1);
    expand(0, K4, 2);
    chk("ignored_start_r10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    expand(0, K4, 3);
    expand(0, K4, 0);
    chk("restart_r10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
